// File: rtl/sobel_window_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_window_gen_if
//  Description : Pixel-stream input and 3x3 window output bundle for the
//                Sobel raster-to-window stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sobel_window_gen_if;
    // Raster pixel stream into the window generator
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_pix;

    // 3x3 neighbourhood, R = row (1 oldest), C = column (1 oldest)
    logic [7:0]  bw11, bw12, bw13;
    logic [7:0]  bw21, bw22, bw23;
    logic [7:0]  bw31, bw32, bw33;
    logic        win_valid;
    logic [10:0] win_x;
    logic [10:0] win_y;
    logic        frame_done;

    // Pixel source / window consumer side
    modport master (
        output in_valid, in_sof, in_pix,
        input  bw11, bw12, bw13, bw21, bw22, bw23, bw31, bw32, bw33,
        input  win_valid, win_x, win_y, frame_done
    );

    // Window generator side
    modport slave (
        input  in_valid, in_sof, in_pix,
        output bw11, bw12, bw13, bw21, bw22, bw23, bw31, bw32, bw33,
        output win_valid, win_x, win_y, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_window_gen
//  Description : Raster-order pixel stream to registered 3x3 window. Two line
//                buffers plus a two-column shift window; a window is emitted
//                for every interior pixel of each frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    sobel_window_gen_if.slave  win_if
);

    localparam int          c_AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [10:0] c_COL_LAST = 11'(IMG_W - 1);
    localparam logic [10:0] c_ROW_LAST = 11'(IMG_H - 1);

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_FILL     = 2'd1,
        ST_STREAM   = 2'd2
    } state_t;

    state_t      r_state;
    logic [10:0] r_col;
    logic [10:0] r_row;

    // lb0 holds row-2, lb1 holds row-1 (contents are never reset)
    logic [7:0]  r_lb0 [0:IMG_W-1];
    logic [7:0]  r_lb1 [0:IMG_W-1];

    // Oldest (col 1) and middle (col 2) window columns; index 0 = top row
    logic [7:0]  r_wc1 [0:2];
    logic [7:0]  r_wc2 [0:2];

    logic              w_sof;
    logic              w_take;
    logic              w_emit;
    logic [10:0]       w_col;
    logic [10:0]       w_row;
    logic [c_AW-1:0]   w_addr;
    logic [7:0]        w_top;
    logic [7:0]        w_mid;
    logic              w_eol;
    logic              w_eof;

    // An accepted sof always lands at (0,0), whatever the counters say
    assign w_sof  = win_if.in_valid & win_if.in_sof;
    assign w_take = w_sof | (win_if.in_valid & (r_state != ST_WAIT_SOF));
    assign w_col  = w_sof ? 11'd0 : r_col;
    assign w_row  = w_sof ? 11'd0 : r_row;
    assign w_addr = w_col[c_AW-1:0];
    assign w_top  = r_lb0[w_addr];
    assign w_mid  = r_lb1[w_addr];
    assign w_eol  = (w_col == c_COL_LAST);
    assign w_eof  = w_eol & (w_row == c_ROW_LAST);
    // STREAM implies row >= 2, so only the column gate is needed here
    assign w_emit = win_if.in_valid & ~win_if.in_sof &
                    (r_state == ST_STREAM) & (r_col >= 11'd2);

    // Line buffers: age row-1 into row-2 and store the new pixel as row-1
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_lb0[w_addr] <= w_mid;
            r_lb1[w_addr] <= win_if.in_pix;
        end
    end

    // Frame FSM, counters, shift window and registered window outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= ST_WAIT_SOF;
            r_col             <= 11'd0;
            r_row             <= 11'd0;
            r_wc1[0]          <= 8'd0;
            r_wc1[1]          <= 8'd0;
            r_wc1[2]          <= 8'd0;
            r_wc2[0]          <= 8'd0;
            r_wc2[1]          <= 8'd0;
            r_wc2[2]          <= 8'd0;
            win_if.bw11       <= 8'd0;
            win_if.bw12       <= 8'd0;
            win_if.bw13       <= 8'd0;
            win_if.bw21       <= 8'd0;
            win_if.bw22       <= 8'd0;
            win_if.bw23       <= 8'd0;
            win_if.bw31       <= 8'd0;
            win_if.bw32       <= 8'd0;
            win_if.bw33       <= 8'd0;
            win_if.win_x      <= 11'd0;
            win_if.win_y      <= 11'd0;
            win_if.win_valid  <= 1'b0;
            win_if.frame_done <= 1'b0;
        end else begin
            win_if.win_valid  <= 1'b0;
            win_if.frame_done <= 1'b0;
            if (w_take) begin
                // The window shifts on every beat so it is full by column 2
                r_wc1[0] <= r_wc2[0];
                r_wc1[1] <= r_wc2[1];
                r_wc1[2] <= r_wc2[2];
                r_wc2[0] <= w_top;
                r_wc2[1] <= w_mid;
                r_wc2[2] <= win_if.in_pix;

                if (w_emit) begin
                    win_if.bw11      <= r_wc1[0];
                    win_if.bw12      <= r_wc2[0];
                    win_if.bw13      <= w_top;
                    win_if.bw21      <= r_wc1[1];
                    win_if.bw22      <= r_wc2[1];
                    win_if.bw23      <= w_mid;
                    win_if.bw31      <= r_wc1[2];
                    win_if.bw32      <= r_wc2[2];
                    win_if.bw33      <= win_if.in_pix;
                    win_if.win_x     <= r_col - 11'd1;
                    win_if.win_y     <= r_row - 11'd1;
                    win_if.win_valid <= 1'b1;
                end

                if (w_eof) begin
                    win_if.frame_done <= 1'b1;
                    r_state           <= ST_WAIT_SOF;
                    r_col             <= 11'd0;
                    r_row             <= 11'd0;
                end else if (w_eol) begin
                    r_col   <= 11'd0;
                    r_row   <= w_row + 11'd1;
                    // Completing row 1 means both line buffers hold this frame
                    r_state <= (w_row == 11'd1) ? ST_STREAM : r_state;
                end else begin
                    r_col   <= w_col + 11'd1;
                    r_row   <= w_row;
                    r_state <= w_sof ? ST_FILL : r_state;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_window_gen
//  Description : Self-checking bench for sobel_window_gen using an image-array
//                reference model and randomized pixel data and gaps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_window_gen;

    localparam int W = 8;
    localparam int H = 6;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sobel_window_gen_if bus ();

    sobel_window_gen #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .win_if (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: the frame as a 2D image plus the current position
    logic [7:0]  img [H][W];
    bit          in_frame;
    int          mr, mc;
    logic [71:0] e_win;
    logic [10:0] e_x, e_y;
    logic        e_vld, e_done;

    int          win_cnt  = 0;
    int          done_cnt = 0;
    logic [93:0] seen [$];

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        in_frame = 1'b0;
        mr = 0;
        mc = 0;
        e_win  = '0;
        e_x    = '0;
        e_y    = '0;
        e_vld  = 1'b0;
        e_done = 1'b0;
    endtask

    // Expected outputs after one clock edge, computed from image coordinates
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_vld  = 1'b0;
        e_done = 1'b0;
        if (bus.in_valid) begin
            if (bus.in_sof) begin
                in_frame = 1'b1;
                mr = 0;
                mc = 0;
            end
            if (in_frame) begin
                img[mr][mc] = bus.in_pix;
                if (mr >= 2 && mc >= 2) begin
                    e_win = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                             img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                             img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
                    e_x   = 11'(mc - 1);
                    e_y   = 11'(mr - 1);
                    e_vld = 1'b1;
                end
                if (mr == H-1 && mc == W-1) begin
                    e_done   = 1'b1;
                    in_frame = 1'b0;
                end
                mc++;
                if (mc == W) begin
                    mc = 0;
                    mr++;
                end
            end
        end
    endtask

    // Called at posedge+2; presents one beat for exactly one clock edge
    task automatic beat(input logic [7:0] pix, input bit sof);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_pix   = pix;
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Sends a frame in raster order, stopping before (stop_r, stop_c)
    task automatic send_frame(input bit rnd, input bit gaps, input int stop_r, input int stop_c);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                beat(rnd ? 8'($urandom) : 8'(16*r + c), (r == 0 && c == 0));
                if (gaps) idle(int'($urandom_range(0, 5)));
            end
        end
    endtask

    int s, d;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pix   = 8'd0;
        rst_n        = 1'b0;
        model_reset();

        fork
            forever begin
                @(posedge clk);
                model_edge();
                @(negedge clk);
                if (!rst_n) model_reset();
                check("win_valid",  96'(bus.win_valid),  96'(e_vld));
                check("frame_done", 96'(bus.frame_done), 96'(e_done));
                check("window", 96'({bus.bw11, bus.bw12, bus.bw13,
                                     bus.bw21, bus.bw22, bus.bw23,
                                     bus.bw31, bus.bw32, bus.bw33}), 96'(e_win));
                check("win_x", 96'(bus.win_x), 96'(e_x));
                check("win_y", 96'(bus.win_y), 96'(e_y));
                if (bus.win_valid) begin
                    win_cnt++;
                    seen.push_back({bus.bw11, bus.bw12, bus.bw13,
                                    bus.bw21, bus.bw22, bus.bw23,
                                    bus.bw31, bus.bw32, bus.bw33,
                                    bus.win_x, bus.win_y});
                end
                if (bus.frame_done) done_cnt++;
            end
        join_none

        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(2);

        // Continuous ramp frame with known first and last windows
        s = win_cnt; d = done_cnt; seen.delete();
        send_frame(1'b0, 1'b0, H, 0);
        idle(3);
        check("s1_count", 96'(win_cnt - s), 96'd24);
        check("s1_done",  96'(done_cnt - d), 96'd1);
        check("s1_first", 96'(seen.size() > 0 ? seen[0] : 94'd0),
              96'({72'h00_01_02_10_11_12_20_21_22, 11'd1, 11'd1}));
        check("s1_last",  96'(seen.size() > 0 ? seen[seen.size()-1] : 94'd0),
              96'({72'h35_36_37_45_46_47_55_56_57, 11'd6, 11'd4}));

        // Same ramp with random idle gaps between beats
        s = win_cnt; d = done_cnt;
        send_frame(1'b0, 1'b1, H, 0);
        idle(3);
        check("s2_count", 96'(win_cnt - s), 96'd24);
        check("s2_done",  96'(done_cnt - d), 96'd1);

        // Beats before any sof are discarded
        s = win_cnt;
        for (int i = 0; i < 5; i++) beat(8'hAA, 1'b0);
        idle(2);
        check("s3_presof", 96'(win_cnt - s), 96'd0);
        s = win_cnt; d = done_cnt;
        send_frame(1'b0, 1'b0, H, 0);
        idle(3);
        check("s3_count", 96'(win_cnt - s), 96'd24);
        check("s3_done",  96'(done_cnt - d), 96'd1);

        // sof reasserted at (3,4) aborts the frame; 8 old windows + 24 new
        s = win_cnt; d = done_cnt;
        send_frame(1'b0, 1'b0, 3, 4);
        send_frame(1'b1, 1'b1, H, 0);
        idle(3);
        check("s4_count", 96'(win_cnt - s), 96'd32);
        check("s4_done",  96'(done_cnt - d), 96'd1);

        // Reset at (4,3), then non-sof beats ignored, then a clean frame
        d = done_cnt;
        send_frame(1'b1, 1'b0, 4, 3);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        s = win_cnt;
        for (int i = 0; i < 4; i++) beat(8'($urandom), 1'b0);
        idle(2);
        check("s5_nosof", 96'(win_cnt - s), 96'd0);
        check("s5_abort_done", 96'(done_cnt - d), 96'd0);
        s = win_cnt; d = done_cnt;
        send_frame(1'b1, 1'b0, H, 0);
        idle(3);
        check("s5_count", 96'(win_cnt - s), 96'd24);
        check("s5_done",  96'(done_cnt - d), 96'd1);

        // Two frames back to back with no gap
        s = win_cnt; d = done_cnt;
        send_frame(1'b1, 1'b0, H, 0);
        send_frame(1'b1, 1'b0, H, 0);
        idle(3);
        check("s6_count", 96'(win_cnt - s), 96'd48);
        check("s6_done",  96'(done_cnt - d), 96'd2);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sobel_window_gen.md
# sobel_window_gen

Raster-to-window stage that feeds the Sobel kernel. It accepts one 8-bit grayscale pixel per valid beat in raster order and keeps two full-line buffers plus a 3x3 shift window. For every interior pixel position it presents a registered 3x3 neighbourhood on nine 8-bit outputs that wire directly to the kernel's bw11..bw33 inputs. Frame position is tracked by an internal column/row counter and FSM, resynchronised by a start-of-frame marker.

## Interface
- IMG_W, 640: pixels per line; legal range 3..2048.
- IMG_H, 480: lines per frame; legal range 3..2048.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; release synchronised externally.
- in_valid  in  1  pixel beat qualifier; gaps of any length are allowed.
- in_sof  in  1  start of frame; sampled only when in_valid=1; marks pixel (row 0, col 0).
- in_pix  in  8  grayscale pixel.
- bw11..bw33  out  8 each  window; bwRC: R=1 top/oldest line, R=3 current line; C=1 leftmost/oldest column, C=3 current column.
- win_valid  out  1  one-cycle strobe; bw outputs hold a new window.
- win_x, win_y  out  11 each  centre coordinate of the presented window (col-1, row-1).
- frame_done  out  1  one-cycle strobe after the last pixel of a frame is accepted.

## Operation
- Beat = clk edge with in_valid=1. Only beats change state; idle cycles freeze all counters, buffers and the window.
- FSM states: WAIT_SOF, FILL, STREAM.
  - WAIT_SOF: beats with in_sof=0 are discarded. A beat with in_sof=1 is taken as pixel (0,0), and the FSM moves to FILL.
  - FILL: rows 0-1. Pixels are written to the line buffers. No windows are emitted. The FSM moves to STREAM when the beat at (1, IMG_W-1) is accepted.
  - STREAM: rows 2..IMG_H-1. A window is emitted for every beat with col>=2.
  - On the beat at (IMG_H-1, IMG_W-1), frame_done is pulsed and the FSM returns to WAIT_SOF.
- in_sof=1 while in FILL or STREAM aborts the current frame. That beat becomes pixel (0,0) of a new frame, the FSM goes to FILL, and no frame_done is produced for the aborted frame. Stale line-buffer content is never exposed, because no window is emitted until row 2.
- Counters: col runs 0..IMG_W-1 and wraps to 0 with row+1. row runs 0..IMG_H-1. Both reset to 0 on rst_n and on every accepted sof.
- Line buffers: two IMG_W x 8 memories. lb1 holds row-1 and lb0 holds row-2. On each beat at column c:
  - read lb0[c] and lb1[c];
  - write lb0[c]<=lb1[c] and lb1[c]<=in_pix.
  - Inferred BRAM or distributed RAM is allowed, provided the external timing below holds.
- Window shift per beat: column 1<=column 2, column 2<=column 3, and the new column 3 = {lb0[c], lb1[c], in_pix} for R=1,2,3. The window shifts on every beat, including non-emitting ones, so that a window is full at col=2.
- Windows never span a line boundary. Per frame there are exactly (IMG_W-2)*(IMG_H-2) windows.
- No arithmetic on pixel values. Outputs are bit-exact copies of input pixels.

## Timing
- Latency: win_valid rises exactly 1 clk after the beat whose pixel lands in bw33. win_valid is never high for 2 cycles on consecutive idle cycles.
- Back-to-back beats produce back-to-back windows; throughput is 1 window per clk. No backpressure exists, and the downstream stage must accept every strobe.
- bw*, win_x and win_y update only together with a win_valid strobe and otherwise hold their last value.
- frame_done asserts 1 clk after the final beat, in the same cycle as that frame's last win_valid.
- Reset values:
  - all bw* = 0x00, win_x = 0, win_y = 0;
  - win_valid = 0, frame_done = 0;
  - FSM = WAIT_SOF, counters = 0.
- Line-buffer contents are not reset.
- Reset mid-frame: outputs clear asynchronously, and the next frame must begin with in_sof.

## Test plan
- IMG_W=8, IMG_H=6, in_pix=16*row+col, continuous beats, sof on first pixel:
  - first win_valid comes 1 clk after pixel 0x22, with bw11=0x00, bw12=0x01, bw13=0x02, bw21=0x10, bw22=0x11, bw23=0x12, bw31=0x20, bw32=0x21, bw33=0x22 and win_x=1, win_y=1;
  - exactly 24 strobes in total;
  - last window has bw33=0x57, win_x=6, win_y=4, with frame_done in the same cycle.
- Same image with a random 0-5 idle cycle gap between beats: identical sequence of 24 windows, with outputs stable during gaps.
- 5 beats with in_sof=0 before sof (values 0xAA): no output activity; the frame then matches the first test exactly.
- in_sof reasserted at (3,4) mid-frame, then a full new frame: no frame_done for the aborted frame, no window before the new row 2, then 24 correct windows.
- rst_n pulsed low at (4,3): all outputs read 0 during reset; after release, beats without sof are ignored and a following sof frame is correct.
- Two consecutive frames with no gap (second sof immediately after the last pixel): 48 windows, two frame_done pulses, and the second frame's first window contains only second-frame pixels.
